// File: rtl/instruction_buffer_mb_if.sv
// Bus bundle for instruction_buffer_mb: AXI-lite-style beat port, clear strobe and fetch port.
// The master drives requests (loader / control unit); the slave is the instruction buffer.
interface instruction_buffer_mb_if #(
    parameter int INS_LEN = 96,
    parameter int DEPTH   = 1024,
    parameter int AXI_DW  = 64
);
    localparam int ROW_W = $clog2(DEPTH);

    logic                axi_icache_en;
    logic                axi_icache_we;
    logic [15:0]         axi_icache_addr;
    logic [AXI_DW-1:0]   axi_icache_wdata;
    logic [AXI_DW-1:0]   axi_icache_rdata;
    logic                icache_clear;
    logic                icache_rd_req_valid;
    logic                icache_rd_req_ready;
    logic [ROW_W-1:0]    icache_rd_addr;
    logic                icache_rd_rsp_valid;
    logic                icache_rd_rsp_ready;
    logic [INS_LEN-1:0]  icache_rd_data;
    logic                icache_rd_miss;
    logic                icache_rd_par_err;

    modport master (
        output axi_icache_en, axi_icache_we, axi_icache_addr, axi_icache_wdata,
        output icache_clear, icache_rd_req_valid, icache_rd_addr, icache_rd_rsp_ready,
        input  axi_icache_rdata, icache_rd_req_ready, icache_rd_rsp_valid,
        input  icache_rd_data, icache_rd_miss, icache_rd_par_err
    );

    modport slave (
        input  axi_icache_en, axi_icache_we, axi_icache_addr, axi_icache_wdata,
        input  icache_clear, icache_rd_req_valid, icache_rd_addr, icache_rd_rsp_ready,
        output axi_icache_rdata, icache_rd_req_ready, icache_rd_rsp_valid,
        output icache_rd_data, icache_rd_miss, icache_rd_par_err
    );
endinterface

// File: rtl/instruction_buffer_mb.sv
// Multi-beat instruction buffer: one RAM bank per AXI beat, per-row beat mask, registered fetch port.
// Optional per-beat even parity is enabled with `define ICACHE_PARITY_EN.
module instruction_buffer_mb #(
    parameter int INS_LEN = 96,
    parameter int DEPTH   = 1024,
    parameter int AXI_DW  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instruction_buffer_mb_if.slave  bus
);
    localparam int BEATS  = (INS_LEN + AXI_DW - 1) / AXI_DW;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ROW_W  = $clog2(DEPTH);
    localparam int LAST_W = INS_LEN - (BEATS - 1) * AXI_DW;

    logic [ROW_W-1:0]   axi_row;
    logic [BEAT_W-1:0]  axi_beat;
    logic               axi_addr_ok;
    logic               axi_wr;
    logic               axi_rd;
    logic               fetch_accept;
    logic               fetch_hit;

    logic [BEATS-1:0]   mask_reg [DEPTH];
    logic               rsp_valid_reg;
    logic               rsp_hit_reg;
    logic               rsp_miss_reg;
    logic               axi_rd_act_reg;
    logic [BEAT_W-1:0]  axi_rd_beat_reg;

    logic [AXI_DW-1:0]  axi_rd_vec [BEATS];
    logic [INS_LEN-1:0] row_flat;
    logic [BEATS-1:0]   par_bad;

    // Upper address bits beyond the row range make the access illegal.
    assign axi_row     = bus.axi_icache_addr[BEAT_W+ROW_W-1:BEAT_W];
    assign axi_beat    = bus.axi_icache_addr[BEAT_W-1:0];
    assign axi_addr_ok = ((bus.axi_icache_addr >> (BEAT_W + ROW_W)) == '0)
                         && (32'(axi_beat) < BEATS);
    assign axi_wr      = bus.axi_icache_en && bus.axi_icache_we && axi_addr_ok;
    assign axi_rd      = bus.axi_icache_en && !bus.axi_icache_we && axi_addr_ok;

    assign bus.icache_rd_req_ready = rst_n && (!rsp_valid_reg || bus.icache_rd_rsp_ready);
    assign fetch_accept = bus.icache_rd_req_valid && bus.icache_rd_req_ready;
    assign fetch_hit    = &mask_reg[bus.icache_rd_addr];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_bank
            // The last bank only stores the bits that belong to the instruction.
            localparam int VW = (gi == BEATS - 1) ? LAST_W : AXI_DW;
            logic [VW-1:0] bank_mem [DEPTH];
            logic [VW-1:0] axi_q;
            logic [VW-1:0] fetch_q;

            always_ff @(posedge clk) begin
                if (axi_wr && axi_beat == BEAT_W'(gi))
                    bank_mem[axi_row] <= bus.axi_icache_wdata[VW-1:0];
                if (axi_rd)
                    axi_q <= bank_mem[axi_row];
                if (fetch_accept)
                    fetch_q <= bank_mem[bus.icache_rd_addr];
            end

            assign axi_rd_vec[gi] = AXI_DW'(axi_q);
            assign row_flat[gi*AXI_DW +: VW] = fetch_q;

`ifdef ICACHE_PARITY_EN
            logic par_mem [DEPTH];
            logic par_q;

            always_ff @(posedge clk) begin
                if (axi_wr && axi_beat == BEAT_W'(gi))
                    par_mem[axi_row] <= ^bus.axi_icache_wdata[VW-1:0];
                if (fetch_accept)
                    par_q <= par_mem[bus.icache_rd_addr];
            end

            assign par_bad[gi] = par_q ^ (^fetch_q);
`else
            assign par_bad[gi] = 1'b0;
`endif
        end
    endgenerate

    // A write coinciding with a clear keeps its own mask bit: the later NBA wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mask_reg[i] <= '0;
        end else begin
            if (bus.icache_clear)
                for (int i = 0; i < DEPTH; i++)
                    mask_reg[i] <= '0;
            if (axi_wr)
                mask_reg[axi_row][axi_beat] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axi_rd_act_reg  <= 1'b0;
            axi_rd_beat_reg <= '0;
        end else begin
            axi_rd_act_reg  <= axi_rd;
            axi_rd_beat_reg <= axi_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_hit_reg   <= 1'b0;
            rsp_miss_reg  <= 1'b0;
        end else if (fetch_accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_hit_reg   <= fetch_hit;
            rsp_miss_reg  <= !fetch_hit;
        end else if (bus.icache_rd_rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign bus.axi_icache_rdata    = axi_rd_act_reg ? axi_rd_vec[axi_rd_beat_reg] : '0;
    assign bus.icache_rd_rsp_valid = rsp_valid_reg;
    assign bus.icache_rd_data      = rsp_hit_reg ? row_flat : '0;
    assign bus.icache_rd_miss      = rsp_miss_reg;
    assign bus.icache_rd_par_err   = rsp_hit_reg && (|par_bad);

endmodule

// File: tb/tb_instruction_buffer_mb.sv
// Directed bench for instruction_buffer_mb (INS_LEN=96, DEPTH=1024, AXI_DW=64).
module tb_instruction_buffer_mb;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic exp_par = 1'b0;

    localparam logic [95:0] ROW3 = 96'hAAAA_BBBB_1111_2222_3333_4444;
    localparam logic [95:0] ROW5 = 96'hCAFE_F00D_0123_4567_89AB_CDEF;

    instruction_buffer_mb_if #(.INS_LEN(96), .DEPTH(1024), .AXI_DW(64)) bus ();

    instruction_buffer_mb #(.INS_LEN(96), .DEPTH(1024), .AXI_DW(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [63:0] data, input logic clr);
        bus.axi_icache_en    = 1'b1;
        bus.axi_icache_we    = 1'b1;
        bus.axi_icache_addr  = addr;
        bus.axi_icache_wdata = data;
        bus.icache_clear     = clr;
        step();
        bus.axi_icache_en    = 1'b0;
        bus.axi_icache_we    = 1'b0;
        bus.icache_clear     = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [15:0] addr, input logic [63:0] exp);
        bus.axi_icache_en   = 1'b1;
        bus.axi_icache_we   = 1'b0;
        bus.axi_icache_addr = addr;
        step();
        bus.axi_icache_en   = 1'b0;
        check({tag, ".rdata"}, bus.axi_icache_rdata, exp);
        step();
        check({tag, ".rdata_idle"}, bus.axi_icache_rdata, 0);
    endtask

    // Single accepted fetch with rsp_ready high; response is checked one cycle later.
    task automatic fetch(input string tag, input logic [9:0] row, input logic clr,
                         input logic [95:0] exp_d, input logic exp_m);
        bus.icache_rd_req_valid = 1'b1;
        bus.icache_rd_addr      = row;
        bus.icache_rd_rsp_ready = 1'b1;
        bus.icache_clear        = clr;
        #1;
        check({tag, ".req_ready"}, bus.icache_rd_req_ready, 1);
        step();
        bus.icache_rd_req_valid = 1'b0;
        bus.icache_clear        = 1'b0;
        check({tag, ".rsp_valid"}, bus.icache_rd_rsp_valid, 1);
        check({tag, ".data"}, bus.icache_rd_data, exp_d);
        check({tag, ".miss"}, bus.icache_rd_miss, exp_m);
        check({tag, ".par_err"}, bus.icache_rd_par_err, exp_par && !exp_m);
        step();
        check({tag, ".rsp_drop"}, bus.icache_rd_rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.axi_icache_en       = 1'b0;
        bus.axi_icache_we       = 1'b0;
        bus.axi_icache_addr     = '0;
        bus.axi_icache_wdata    = '0;
        bus.icache_clear        = 1'b0;
        bus.icache_rd_req_valid = 1'b0;
        bus.icache_rd_addr      = '0;
        bus.icache_rd_rsp_ready = 1'b0;

        // 1: reset state, then fetch of an empty row
        step();
        check("rst.rsp_valid", bus.icache_rd_rsp_valid, 0);
        check("rst.req_ready", bus.icache_rd_req_ready, 0);
        check("rst.rdata", bus.axi_icache_rdata, 0);
        check("rst.data", bus.icache_rd_data, 0);
        check("rst.miss", bus.icache_rd_miss, 0);
        step();
        rst_n = 1'b1;
        step();
        fetch("t1.row0", 10'd0, 1'b0, 96'h0, 1'b1);

        // 2: two-beat load of row 3, fetch and AXI read-back
        axi_write(16'h0006, 64'h1111_2222_3333_4444, 1'b0);
        axi_write(16'h0007, 64'hFFFF_FFFF_AAAA_BBBB, 1'b0);
        fetch("t2.row3", 10'd3, 1'b0, ROW3, 1'b0);
        axi_read("t2.rd7", 16'h0007, 64'h0000_0000_AAAA_BBBB);
        axi_read("t2.rd6", 16'h0006, 64'h1111_2222_3333_4444);

        // Out-of-range addresses are ignored on write and read as 0
        axi_write(16'h0800, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);
        axi_write(16'h0801, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);
        axi_read("t2.rd_oor", 16'h0800, 64'h0);
        fetch("t2.row0_oor", 10'd0, 1'b0, 96'h0, 1'b1);

        // 3: partial row 5 misses until both beats are loaded
        axi_write(16'h000A, 64'h0123_4567_89AB_CDEF, 1'b0);
        fetch("t3.partial", 10'd5, 1'b0, 96'h0, 1'b1);
        axi_write(16'h000B, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        fetch("t3.full", 10'd5, 1'b0, ROW5, 1'b0);

        // 4: back-pressure holds the response and blocks new accepts
        bus.icache_rd_req_valid = 1'b1;
        bus.icache_rd_addr      = 10'd3;
        bus.icache_rd_rsp_ready = 1'b0;
        step();
        bus.icache_rd_addr = 10'd5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4.hold%0d.valid", i), bus.icache_rd_rsp_valid, 1);
            check($sformatf("t4.hold%0d.req_ready", i), bus.icache_rd_req_ready, 0);
            check($sformatf("t4.hold%0d.data", i), bus.icache_rd_data, ROW3);
            if (i < 3) step();
        end
        bus.icache_rd_rsp_ready = 1'b1;
        #1;
        check("t4.release.req_ready", bus.icache_rd_req_ready, 1);
        step();
        bus.icache_rd_req_valid = 1'b0;
        check("t4.next.valid", bus.icache_rd_rsp_valid, 1);
        check("t4.next.data", bus.icache_rd_data, ROW5);
        step();
        check("t4.drop", bus.icache_rd_rsp_valid, 0);

        // 5: clear alongside a fetch sees pre-clear masks; clear alongside a write keeps that bit
        fetch("t5.clr_fetch", 10'd3, 1'b1, ROW3, 1'b0);
        fetch("t5.after_clr", 10'd3, 1'b0, 96'h0, 1'b1);
        axi_write(16'h000A, 64'h1111_1111_1111_1111, 1'b1);
        axi_write(16'h000B, 64'h2222_2222_2222_2222, 1'b0);
        fetch("t5.wr_wins", 10'd5, 1'b0, 96'h2222_2222_1111_1111_1111_1111, 1'b0);

        // 6: flip stored bit 70 (beat 1, bit 6) of row 3
        axi_write(16'h0006, 64'h1111_2222_3333_4444, 1'b0);
        axi_write(16'h0007, 64'hFFFF_FFFF_AAAA_BBBB, 1'b0);
        fetch("t6.clean", 10'd3, 1'b0, ROW3, 1'b0);
        dut.g_bank[1].bank_mem[3][6] <= ~dut.g_bank[1].bank_mem[3][6];
        #1;
`ifdef ICACHE_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        fetch("t6.flipped", 10'd3, 1'b0, 96'hAAAA_BBFB_1111_2222_3333_4444, 1'b0);
        exp_par = 1'b0;

        // Reset mid-handshake drops rsp_valid at once and nothing is replayed
        bus.icache_rd_req_valid = 1'b1;
        bus.icache_rd_addr      = 10'd5;
        bus.icache_rd_rsp_ready = 1'b0;
        step();
        bus.icache_rd_req_valid = 1'b0;
        check("rst_mid.before", bus.icache_rd_rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.async_drop", bus.icache_rd_rsp_valid, 0);
        step();
        rst_n = 1'b1;
        bus.icache_rd_rsp_ready = 1'b1;
        step();
        check("rst_mid.no_replay", bus.icache_rd_rsp_valid, 0);
        fetch("rst_mid.masks_cleared", 10'd5, 1'b0, 96'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instruction_buffer_mb.md
Name: instruction_buffer_mb

Overview:
- Parametrised successor to the single-beat instruction store.
- Holds DEPTH instructions of arbitrary INS_LEN, loaded over the 64-bit AXI-lite-style slave port as multiple beats per instruction.
- Tracks per-row valid state.
- Serves the control unit through a registered valid/ready fetch port with back-pressure.

Parameters:
- INS_LEN, 96, instruction width in bits (1..256).
- DEPTH, 1024, number of instruction rows (power of two).
- AXI_DW, 64, AXI data width.
- Derived localparams, not overridable:
  - BEATS = ceil(INS_LEN/AXI_DW).
  - BEAT_W = max(1, clog2(BEATS)).
  - ROW_W = clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_icache_en  in  1  AXI access strobe.
- axi_icache_we  in  1  1 = write, 0 = read.
- axi_icache_addr  in  16  beat address: row = addr[BEAT_W+ROW_W-1:BEAT_W], beat = addr[BEAT_W-1:0].
- axi_icache_wdata  in  AXI_DW  write beat.
- axi_icache_rdata  out  AXI_DW  read beat.
- icache_clear  in  1  pulse; invalidates all rows.
- icache_rd_req_valid  in  1  fetch request.
- icache_rd_req_ready  out  1  fetch request accepted.
- icache_rd_addr  in  ROW_W  fetch row.
- icache_rd_rsp_valid  out  1  response valid.
- icache_rd_rsp_ready  in  1  consumer ready.
- icache_rd_data  out  INS_LEN  fetched instruction.
- icache_rd_miss  out  1  response row was not fully loaded.
- icache_rd_par_err  out  1  parity error (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-low. Every output is 0 during reset.
  - Reset also clears the beat-mask array (DEPTH x BEATS bits), the response register and the AXI read pipeline.
  - The data array is not reset.
- Storage:
  - Beat b of a row holds instruction bits [b*AXI_DW +: AXI_DW].
  - Last-beat bits above INS_LEN are discarded on write and read back as 0.
- AXI write (en & we):
  - Beat is written at the clock edge and its mask bit is set.
  - If beat >= BEATS or the address exceeds the row range, the write is ignored.
  - A row is valid when all BEATS mask bits are set.
- AXI read (en & !we):
  - 1-cycle latency: rdata shows the addressed beat in the cycle after the request.
  - rdata is 0 in every other cycle, and also for an illegal beat index.
  - A read of a beat written in the same cycle returns the old data.
- icache_clear:
  - Clears all mask bits at the edge.
  - If clear coincides with an AXI write, the written beat's mask bit ends up set; the write wins for that bit.
- Fetch port:
  - icache_rd_req_ready = !icache_rd_rsp_valid | icache_rd_rsp_ready. It is combinational and never depends on req_valid.
  - On accept (req_valid & req_ready) the response register loads on the next edge:
    - rsp_valid = 1.
    - data = the full row if valid; otherwise data = 0 and miss = 1.
  - While rsp_valid & !rsp_ready, data, miss and par_err hold stable.
  - When rsp_ready is high and no new request is accepted, rsp_valid drops to 0 the next cycle.
  - Back-to-back accepts give one response per cycle, with throughput 1.
  - A fetch accepted in the same cycle as an AXI write to the same row samples pre-write contents and pre-write mask.
  - A fetch accepted in the same cycle as icache_clear sees pre-clear masks.
- Reset mid-handshake drops rsp_valid immediately (asynchronously). No response is replayed after reset.

Optional Feature:
- Macro: ICACHE_PARITY_EN.
- Defined:
  - One even-parity bit is stored per beat, computed on write.
  - On fetch, all beats are checked. icache_rd_par_err = 1 with the response if any beat mismatches on a valid row.
  - On a parity error, data is still returned.
  - AXI reads do not check parity.
- Undefined: no parity storage; icache_rd_par_err is tied to 0.

Test Plan (INS_LEN=96, DEPTH=1024, BEATS=2, BEAT_W=1):
1. Reset, then fetch row 0 -> rsp_valid one cycle after accept, data=0, miss=1.
2. AXI write addr 0x0006 = 0x1111_2222_3333_4444, then addr 0x0007 = 0xFFFF_FFFF_AAAA_BBBB; fetch row 3:
   - data = 0xAAAA_BBBB_1111_2222_3333_4444, miss=0.
   - AXI read 0x0007 returns 0x0000_0000_AAAA_BBBB one cycle later.
3. Write only beat 0 of row 5, fetch row 5 -> miss=1, data=0. Write beat 1, fetch again -> miss=0.
4. Valid row 3, hold rsp_ready=0 for 4 cycles while req_valid=1:
   - req_ready=0 after the first accept.
   - Response holds the row-3 value unchanged.
   - Release ready -> next accepted request is answered on the following cycle.
5. Assert icache_clear in the same cycle as an accepted fetch of row 3:
   - That response has miss=0.
   - A following fetch of row 3 gets miss=1.
6. With ICACHE_PARITY_EN defined, force-flip stored bit 70 of row 3 via the bench hierarchy, then fetch -> par_err=1 with the flipped data. Without the macro -> par_err=0.
